sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares one 16Mx16 SDRAM controller port between NPORTS requesters.
- Typical requesters: core instruction fetch, core data, DMA/debug.
- Each requester and the controller use the same valid/ready convention. Requester and controller valid are held; ready is a one-cycle pulse.
- Grants are round-robin. Address, data and mask of the granted port are held stable for the whole controller transaction, because the controller re-reads addr during its column phase.

Parameters:
- NPORTS, 2, number of requester ports (2..4).
- TIMEOUT, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- CLK  in  1  system clock, shared with the SDRAM controller.
- RES  in  1  synchronous reset, active-high.
- s_valid  in  NPORTS  per-port request; held until that port's s_ready.
- s_addr  in  NPORTS*25  per-port byte address {bank/row/col}; port i occupies [25*i+24:25*i].
- s_din  in  NPORTS*32  per-port write data.
- s_wmask  in  NPORTS*4  per-port byte enables; 0 = read.
- s_dout  out  32  read data, common to all ports; valid while s_ready[i].
- s_ready  out  NPORTS  one-cycle completion pulse per port.
- m_addr  out  25  to controller addr.
- m_din  out  32  to controller din.
- m_wmask  out  4  to controller wmask.
- m_valid  out  1  to controller valid.
- m_dout  in  32  from controller dout.
- m_ready  in  1  from controller ready pulse.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: state=ARB, grant=0, rr_ptr=0, m_valid=0, m_addr/m_din/m_wmask=0, s_ready=0, s_dout=0, err=0.
- FSM: ARB -> BUSY -> RELEASE -> ARB.
- ARB: m_valid=0.
  - If any s_valid is set, pick the first set port scanning from rr_ptr upward, wrapping modulo NPORTS.
  - Register grant and latch that port's addr/din/wmask into m_addr/m_din/m_wmask, then go to BUSY.
  - If no request, stay in ARB.
- BUSY: m_valid=1. Held m_* fields do not change even if s_* inputs change.
  - On m_ready: s_dout<=m_dout, s_ready[grant]<=1, rr_ptr<=grant+1 (mod NPORTS), go to RELEASE.
- RELEASE: m_valid=0, s_ready[grant]=1 for exactly this cycle, next state ARB.
  - This cycle covers the controller's idle cycle in which ready is still high. It also gives the requester one edge to drop or re-issue valid.
- Latency, uncontended: s_valid seen in ARB cycle t; m_valid high at t+1; s_ready pulses one cycle after m_ready.
  - Minimum arbiter overhead is 2 cycles of m_valid=0 between transactions.
- m_valid is registered, never combinational from s_valid.
- s_ready is one-hot or zero; at most one pulse per granted transaction.
- Simultaneous requests: strict rotation, so no port waits more than NPORTS-1 transactions.
- A port whose s_valid drops while not granted is simply skipped.
- Dropping s_valid while granted is illegal; the transaction completes regardless.
- m_ready outside BUSY is ignored.
- Reset mid-transaction: the arbiter returns to ARB immediately. The controller must be reset in the same cycle; RES maps to controller resetn=~RES at top level.

Optional Feature:
- Macro SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - Cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without m_ready: s_dout<=32'hDEADBEEF, s_ready[grant] pulses, err<=1 (sticky until RES), go to RELEASE as normal.
- Undefined: no counter; err tied 0; BUSY waits indefinitely.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encodings ARB/BUSY/RELEASE;
  - widths ADDR_W=25, DATA_W=32, MASK_W=4;
  - timeout data constant 32'hDEADBEEF.
- Sub-module rr_picker: combinational priority scan from rr_ptr returning grant index plus any_valid. It is reused later for peripheral bus arbitration.

Test Plan:
- Single read, port 0, addr=25'h0000400, controller model returns 32'h12345678: m_valid rises 1 cycle after s_valid; s_ready[0] pulses once with s_dout=32'h12345678.
- Single write, port 1, din=32'hCAFEF00D, wmask=4'b0011: m_din/m_wmask match and stay stable through BUSY; s_ready[1] pulses once.
- Both ports request continuously from reset for 6 transactions: grants alternate 0,1,0,1,0,1 and m_valid is 0 for exactly 2 cycles between transactions.
- s_addr[0] changes mid-BUSY: m_addr holds the originally latched value until RELEASE.
- m_ready pulse in ARB with no grant: ignored, no s_ready pulse.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT=16, controller never answers: s_ready pulses after 16 BUSY cycles with s_dout=32'hDEADBEEF, err=1 sticky; RES clears err.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Round-robin picker: returns the first set request found scanning upward
// from i_ptr and wrapping modulo NPORTS, plus a flag that any request is set.
module rr_picker #(
    parameter int NPORTS = 2,
    parameter int PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] i_valid,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [PTR_W-1:0]  o_grant,
    output logic              o_any
);

    int w_idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        // Scan from the farthest offset down so the nearest request wins last.
        for (int k = NPORTS - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NPORTS;
            if (i_valid[w_idx]) begin
                o_grant = PTR_W'(w_idx);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between NPORTS
// requesters. Define SDRAM_ARB_TIMEOUT_EN to enable the BUSY watchdog.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     CLK,
    input  logic                     RES,
    input  logic [NPORTS-1:0]        s_valid,
    input  logic [NPORTS*ADDR_W-1:0] s_addr,
    input  logic [NPORTS*DATA_W-1:0] s_din,
    input  logic [NPORTS*MASK_W-1:0] s_wmask,
    output logic [DATA_W-1:0]        s_dout,
    output logic [NPORTS-1:0]        s_ready,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_din,
    output logic [MASK_W-1:0]        m_wmask,
    output logic                     m_valid,
    input  logic [DATA_W-1:0]        m_dout,
    input  logic                     m_ready,
    output logic                     err
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    if (NPORTS < 2 || NPORTS > 4 || TIMEOUT < 1) begin : g_bad_params
        $error("sdram_arbiter: NPORTS must be 2..4 and TIMEOUT at least 1");
    end

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [PTR_W-1:0]  r_grant;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_pick;
    logic              w_any;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_resp_data;
    logic [PTR_W-1:0]  w_ptr_after;

    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_din;
    logic [MASK_W-1:0] r_m_wmask;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_s_dout;
    logic [NPORTS-1:0] r_s_ready;

    rr_picker #(
        .NPORTS (NPORTS),
        .PTR_W  (PTR_W)
    ) u_picker (
        .i_valid (s_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_busy_cnt;
    logic             r_err;

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_busy_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state != ST_BUSY) begin
                r_busy_cnt <= '0;
            end else if (!m_ready) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Fires on the TIMEOUT-th BUSY cycle when the controller has not answered.
    assign w_timeout = (r_state == ST_BUSY) && !m_ready &&
                       (r_busy_cnt == CNT_W'(TIMEOUT - 1));
    assign err       = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign w_done      = (r_state == ST_BUSY) && (m_ready || w_timeout);
    assign w_resp_data = w_timeout ? TIMEOUT_DATA : m_dout;
    assign w_ptr_after = (r_grant == PTR_W'(NPORTS - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB:     if (w_any)  w_next_state = ST_BUSY;
            ST_BUSY:    if (w_done) w_next_state = ST_RELEASE;
            ST_RELEASE: w_next_state = ST_ARB;
            default:    w_next_state = ST_ARB;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_m_addr  <= '0;
            r_m_din   <= '0;
            r_m_wmask <= '0;
            r_m_valid <= 1'b0;
            r_s_dout  <= '0;
            r_s_ready <= '0;
        end else begin
            r_s_ready <= '0;
            r_m_valid <= (w_next_state == ST_BUSY);
            case (r_state)
                ST_ARB: begin
                    // The controller re-reads addr in its column phase, so the
                    // granted request is captured once and held through BUSY.
                    if (w_any) begin
                        r_grant   <= w_pick;
                        r_m_addr  <= s_addr[w_pick*ADDR_W +: ADDR_W];
                        r_m_din   <= s_din[w_pick*DATA_W +: DATA_W];
                        r_m_wmask <= s_wmask[w_pick*MASK_W +: MASK_W];
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_s_dout           <= w_resp_data;
                        r_s_ready[r_grant] <= 1'b1;
                        r_rr_ptr           <= w_ptr_after;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_addr  = r_m_addr;
    assign m_din   = r_m_din;
    assign m_wmask = r_m_wmask;
    assign m_valid = r_m_valid;
    assign s_dout  = r_s_dout;
    assign s_ready = r_s_ready;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed cases with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int NP  = 3;
    localparam int TMO = 16;

    logic                 clk = 1'b0;
    logic                 res;
    logic [NP-1:0]        s_valid;
    logic [NP*ADDR_W-1:0] s_addr;
    logic [NP*DATA_W-1:0] s_din;
    logic [NP*MASK_W-1:0] s_wmask;
    logic [DATA_W-1:0]    s_dout;
    logic [NP-1:0]        s_ready;
    logic [ADDR_W-1:0]    m_addr;
    logic [DATA_W-1:0]    m_din;
    logic [MASK_W-1:0]    m_wmask;
    logic                 m_valid;
    logic [DATA_W-1:0]    m_dout;
    logic                 m_ready;
    logic                 err;

    int checks   = 0;
    int failures = 0;

    sdram_arbiter #(
        .NPORTS  (NP),
        .TIMEOUT (TMO)
    ) dut (
        .CLK     (clk),
        .RES     (res),
        .s_valid (s_valid),
        .s_addr  (s_addr),
        .s_din   (s_din),
        .s_wmask (s_wmask),
        .s_dout  (s_dout),
        .s_ready (s_ready),
        .m_addr  (m_addr),
        .m_din   (m_din),
        .m_wmask (m_wmask),
        .m_valid (m_valid),
        .m_dout  (m_dout),
        .m_ready (m_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Transaction-level model: one outstanding transaction, a pointer to the
    // port after the last one served, and a one-cycle release after completion.
    bit              md_busy;
    bit              md_rel;
    int              md_grant;
    int              md_ptr;
    int              md_busy_cycles;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_din;
    logic [MASK_W-1:0] md_mask;
    logic [NP-1:0]     md_ready;
    logic [DATA_W-1:0] md_dout;
    bit              md_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void finish_txn(input logic [DATA_W-1:0] data);
        md_dout            = data;
        md_ready[md_grant] = 1'b1;
        md_ptr             = (md_grant + 1) % NP;
        md_busy            = 1'b0;
        md_rel             = 1'b1;
    endfunction

    function automatic void model_step(input logic r, input logic [NP-1:0] v,
                                       input logic [NP*ADDR_W-1:0] a,
                                       input logic [NP*DATA_W-1:0] d,
                                       input logic [NP*MASK_W-1:0] m,
                                       input logic mr, input logic [DATA_W-1:0] md);
        bit found;
        int p;
        if (r) begin
            md_busy = 0; md_rel = 0; md_grant = 0; md_ptr = 0; md_busy_cycles = 0;
            md_addr = '0; md_din = '0; md_mask = '0; md_ready = '0; md_dout = '0;
            md_err = 0;
            return;
        end
        md_ready = '0;
        if (md_busy) begin
            md_busy_cycles++;
            if (mr) begin
                finish_txn(md);
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            else if (md_busy_cycles == TMO) begin
                finish_txn(32'hDEADBEEF);
                md_err = 1'b1;
            end
`endif
        end else if (md_rel) begin
            md_rel = 1'b0;
        end else begin
            found = 0;
            for (int k = 0; k < NP; k++) begin
                p = (md_ptr + k) % NP;
                if (!found && v[p]) begin
                    found    = 1;
                    md_grant = p;
                end
            end
            if (found) begin
                md_busy        = 1'b1;
                md_busy_cycles = 0;
                md_addr        = a[md_grant*ADDR_W +: ADDR_W];
                md_din         = d[md_grant*DATA_W +: DATA_W];
                md_mask        = m[md_grant*MASK_W +: MASK_W];
            end
        end
    endfunction

    task automatic compare_all();
        check("m_valid", {63'd0, m_valid}, {63'd0, md_busy});
        check("s_ready", 64'(s_ready), 64'(md_ready));
        check("s_dout", 64'(s_dout), 64'(md_dout));
        check("m_addr", 64'(m_addr), 64'(md_addr));
        check("m_din", 64'(m_din), 64'(md_din));
        check("m_wmask", 64'(m_wmask), 64'(md_mask));
        check("err", {63'd0, err}, {63'd0, md_err});
    endtask

    // One clock: capture the inputs the edge will see, advance the model,
    // then compare the DUT just after the edge.
    task automatic tick();
        logic                 c_res = res;
        logic [NP-1:0]        c_v   = s_valid;
        logic [NP*ADDR_W-1:0] c_a   = s_addr;
        logic [NP*DATA_W-1:0] c_d   = s_din;
        logic [NP*MASK_W-1:0] c_m   = s_wmask;
        logic                 c_mr  = m_ready;
        logic [DATA_W-1:0]    c_md  = m_dout;
        @(posedge clk);
        model_step(c_res, c_v, c_a, c_d, c_m, c_mr, c_md);
        #1;
        compare_all();
    endtask

    task automatic set_port(input int p, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        s_addr[p*ADDR_W +: ADDR_W]  = a;
        s_din[p*DATA_W +: DATA_W]   = d;
        s_wmask[p*MASK_W +: MASK_W] = m;
    endtask

    function automatic int onehot_idx(input logic [NP-1:0] v);
        int idx = -1;
        for (int i = 0; i < NP; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    bit pend [NP];
    int ctl_wait;
    int grants[$];
    int gaps[$];

    initial begin
        int  zero_run;
        bit  seen_busy;
        bit  prev_mv;
        int  busy_seen;

        res = 1'b1; s_valid = '0; s_addr = '0; s_din = '0; s_wmask = '0;
        m_dout = '0; m_ready = 1'b0;
        tick(); tick();
        res = 1'b0;
        tick();
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_s_dout", 64'(s_dout), 64'd0);

        // Single read on port 0, with the port's address changing mid-BUSY.
        set_port(0, 25'h0000400, 32'h0, 4'h0);
        s_valid = 3'b001;
        tick();
        check("t1_m_valid_rise", {63'd0, m_valid}, 64'd1);
        check("t1_m_addr", 64'(m_addr), 64'h400);
        set_port(0, 25'h1FFFFFF, 32'h5555AAAA, 4'hF);
        tick();
        check("t1_m_addr_held", 64'(m_addr), 64'h400);
        check("t1_m_wmask_held", 64'(m_wmask), 64'h0);
        tick();
        m_ready = 1'b1; m_dout = 32'h12345678;
        tick();
        check("t1_s_ready", 64'(s_ready), 64'b001);
        check("t1_s_dout", 64'(s_dout), 64'h12345678);
        check("t1_m_valid_low", {63'd0, m_valid}, 64'd0);
        s_valid = '0;
        tick();
        check("t1_single_pulse", 64'(s_ready), 64'd0);
        m_ready = 1'b0;
        tick();

        // Single write on port 1.
        set_port(1, 25'h0ABCDE0, 32'hCAFEF00D, 4'b0011);
        s_valid = 3'b010;
        tick();
        check("t2_m_din", 64'(m_din), 64'hCAFEF00D);
        check("t2_m_wmask", 64'(m_wmask), 64'h3);
        set_port(1, 25'h1555555, 32'h0, 4'hF);
        tick();
        check("t2_m_din_held", 64'(m_din), 64'hCAFEF00D);
        check("t2_m_addr_held", 64'(m_addr), 64'h0ABCDE0);
        m_ready = 1'b1; m_dout = 32'h0BADF00D;
        tick();
        check("t2_s_ready", 64'(s_ready), 64'b010);
        m_ready = 1'b0; s_valid = '0;
        tick();
        check("t2_single_pulse", 64'(s_ready), 64'd0);
        tick();

        // Stray m_ready while idle is ignored.
        m_ready = 1'b1;
        repeat (3) begin
            tick();
            check("t4_no_ready", 64'(s_ready), 64'd0);
            check("t4_no_valid", {63'd0, m_valid}, 64'd0);
        end
        m_ready = 1'b0;

        // Ports 0 and 1 request continuously from reset.
        res = 1'b1;
        tick();
        res = 1'b0;
        set_port(0, 25'h0000100, 32'h11111111, 4'h0);
        set_port(1, 25'h0000200, 32'h22222222, 4'hF);
        s_valid = 3'b011;
        zero_run = 0; seen_busy = 0; prev_mv = 0;
        for (int c = 0; c < 80 && grants.size() < 6; c++) begin
            m_ready = m_valid;
            m_dout  = 32'(c);
            tick();
            if (s_ready != '0) grants.push_back(onehot_idx(s_ready));
            if (m_valid) begin
                if (seen_busy && !prev_mv) gaps.push_back(zero_run);
                seen_busy = 1; zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_mv = m_valid;
        end
        check("t3_txn_count", 64'(grants.size()), 64'd6);
        check("t3_gap_count", 64'(gaps.size()), 64'd5);
        foreach (grants[i]) check("t3_grant_order", 64'(grants[i]), 64'(i % 2));
        foreach (gaps[i]) check("t3_idle_gap", 64'(gaps[i]), 64'd2);
        s_valid = '0; m_ready = 1'b0;
        tick(); tick();

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Controller never answers: watchdog completes the transaction.
        set_port(0, 25'h0000040, 32'h0, 4'h0);
        s_valid = 3'b001;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (m_valid) busy_seen++;
            if (s_ready != '0) break;
        end
        check("t5_busy_cycles", 64'(busy_seen), 64'd16);
        check("t5_s_ready", 64'(s_ready), 64'b001);
        check("t5_s_dout", 64'(s_dout), 64'hDEADBEEF);
        check("t5_err_set", {63'd0, err}, 64'd1);
        s_valid = '0;
        repeat (3) tick();
        check("t5_err_sticky", {63'd0, err}, 64'd1);
        res = 1'b1;
        tick();
        res = 1'b0;
        check("t5_err_cleared", {63'd0, err}, 64'd0);
`else
        busy_seen = 0;
        check("err_tied_low", {63'd0, err}, 64'd0);
`endif

        // Randomized traffic against the model.
        res = 1'b1;
        tick();
        res = 1'b0;
        for (int i = 0; i < NP; i++) pend[i] = 0;
        ctl_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            res = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NP; i++) begin
                if (res) begin
                    pend[i] = 0;
                end else if (pend[i] && md_ready[i]) begin
                    pend[i] = ($urandom_range(0, 1) == 1);
                    if (pend[i]) set_port(i, 25'($urandom), $urandom,
                                          ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
                end else if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[i] = 1;
                        set_port(i, 25'($urandom), $urandom,
                                 ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
                    end
                end else if (md_busy && md_grant == i) begin
                    if ($urandom_range(0, 3) == 0)
                        set_port(i, 25'($urandom), $urandom, 4'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 0;
                end
                s_valid[i] = pend[i];
            end
            m_dout = $urandom;
            if (md_busy) begin
                if (ctl_wait == 0) begin
                    m_ready = 1'b1;
                end else begin
                    m_ready = 1'b0;
                    ctl_wait--;
                end
            end else begin
                m_ready  = ($urandom_range(0, 3) == 0);
                ctl_wait = $urandom_range(0, 4);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
